egress_drain: RTL and testbench
===============================

# egress_drain

Downstream egress stage of the transaction layer. It drains the four blue output FIFOs into a single 12-bit stream with a valid/ready handshake toward the link layer. Ports are chosen round-robin (or by strict priority when configured). The block keeps a 2-entry output buffer and per-port delivered-word counters that are read through a req/idx interface.

## Interface
Parameters:
- DATA_W, 12: word width (class[11:10], dest[9:8], payload[7:0]).
- CNT_W, 5: per-port delivered counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- Enable  in  1  allows new pops when high.
- empty_azules  in  4  empty flags of blue FIFOs p0..p3.
- data_p0..data_p3  in  12 each  FIFO_data_out of blue FIFOs; valid the cycle after pop.
- pop_azules  out  4  one-hot or zero read enable to the blue FIFOs.
- ready_in  in  1  sink accepts data_out this cycle.
- data_out  out  12  head word of the output buffer.
- valid_out  out  1  data_out is valid.
- port_out  out  2  source port of data_out.
- req  in  1  counter read request.
- idx  in  2  counter index for req.
- cnt_data  out  5  counter value.
- cnt_valid  out  1  cnt_data is valid.
- idle  out  1  high in IDLE state.

## Operation
- States: IDLE, RUN, STALL, DRAIN.
  - IDLE→RUN when Enable=1 and any empty_azules bit is 0.
  - RUN→STALL when the buffer holds 2 words and ready_in=0.
  - STALL→RUN when ready_in=1.
  - RUN/STALL→DRAIN when Enable=0.
  - DRAIN→IDLE when the buffer is empty and no word is in flight.
  - DRAIN→RUN when Enable returns to 1.
- Pop eligibility: port p is eligible iff empty_azules[p]=0 and p was not popped in the previous cycle. The mask exists because the registered empty flag is one cycle stale.
- Credit rule: a pop is issued only if occ + inflight − deq < 2. Here occ is buffer occupancy (0..2), inflight is a pop issued last cycle, and deq = valid_out & ready_in.
- No pops are issued in IDLE, STALL or DRAIN, or while reset is high.
- Round-robin: the grant goes to the first eligible port after the last granted port (wrap 3→0). The pointer updates only on a grant.
- Capture: the cycle after pop_azules[p] is asserted, data_p<p> is written to the buffer tail together with tag p.
- An enqueue and a dequeue in the same cycle leave occ unchanged.
- The buffer is a FIFO: data_out, port_out and valid_out come from the head entry and are registered.
- Counters:
  - cnt[p] increments on each accepted dequeue whose port_out = p, wrapping 31→0.
  - req=1 → cnt_data = cnt[idx] and cnt_valid = 1 on the next cycle; otherwise cnt_valid = 0 and cnt_data holds its value.
  - A read and an increment in the same cycle return the pre-increment value.
- Reset mid-operation discards buffered and in-flight words; that FIFO data is lost and the bench must not expect it.

## Timing
- Reset values: pop_azules 0, data_out 0, valid_out 0, port_out 0, cnt_data 0, cnt_valid 0, idle 1, all counters 0, RR pointer 3 (port 0 wins first), state IDLE.
- pop_azules is combinational from registered state plus empty_azules, ready_in and Enable.
- Latency from pop to valid_out is 2 cycles: pop at N, capture at N+1, valid_out at N+2 if the buffer was empty.
- Throughput is 1 word/cycle when ≥2 ports are non-empty and ready_in=1, and 1 word per 2 cycles with a single active port.
- Holding rule: data_out, port_out and valid_out must not change while valid_out=1 and ready_in=0.

## Configuration
- EGRESS_STRICT_PRIO_EN defined: grant goes to the lowest-numbered eligible port (p0 highest) and the RR pointer is removed.
- Undefined: round-robin as above. All other behaviour is identical.

## Structure
- Shared package egress_pkg holds:
  - state encoding (IDLE=0, RUN=1, STALL=2, DRAIN=3);
  - NUM_PORTS=4, DATA_W=12, CNT_W=5, BUF_DEPTH=2.
- Sub-module rr_arbiter_4 takes request[3:0], last grant and enable, and produces a one-hot grant plus the next pointer. The strict-priority variant lives inside it under the macro.

## Test plan
- Reset, then a single pop cycle: after reset all outputs hold their reset values and idle=1. Reset asserted one cycle after a pop → no valid_out, occ 0.
- p0..p3 non-empty with data 0x001/0x102/0x203/0x304 and ready_in=1 → valid_out words in port order 0,1,2,3 from cycle N+2 onward, 1 word/cycle.
- Only p2 non-empty with 3 words → pops on alternate cycles, port_out=2, three words delivered.
- ready_in=0 with all ports full → at most 2 words buffered, pops stop, STALL entered, data_out stable. Releasing ready_in → resumes with no loss or duplication.
- Enable dropped while 1 word is in flight → DRAIN, the in-flight word is delivered, then IDLE with idle=1.
- After 33 accepted words on p1, req=1 with idx=1 → next cycle cnt_valid=1 and cnt_data=1 (wrap). With EGRESS_STRICT_PRIO_EN and all ports non-empty → p0 is granted whenever eligible.

Source files
------------

// File: rtl/egress_pkg.sv
// egress_pkg: shared constants and FSM state type for the egress drain stage.
//   NUM_PORTS : number of blue FIFOs drained
//   DATA_W    : word width {class[11:10], dest[9:8], payload[7:0]}
//   CNT_W     : per-port delivered counter width
//   BUF_DEPTH : output buffer entries
package egress_pkg;

   localparam int unsigned NUM_PORTS = 4;
   localparam int unsigned DATA_W    = 12;
   localparam int unsigned CNT_W     = 5;
   localparam int unsigned BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/egress_drain_rr_arbiter_4.sv
// rr_arbiter_4: 4-way combinational arbiter for the egress drain stage.
//   request    in  4  eligible ports
//   last_grant in  2  last granted port (RR pointer)
//   enable     in  1  grant allowed this cycle
//   grant      out 4  one-hot grant, zero when disabled or no request
//   next_ptr   out 2  encoded grant; equals last_grant when nothing is granted
// Macro EGRESS_STRICT_PRIO_EN: lowest-numbered requester wins, last_grant
// only serves as the idle value of next_ptr.
module rr_arbiter_4
(
   input  logic [3:0] request,
   input  logic [1:0] last_grant,
   input  logic       enable,
   output logic [3:0] grant,
   output logic [1:0] next_ptr
);

   import egress_pkg::*;

`ifdef EGRESS_STRICT_PRIO_EN
   always_comb begin
      grant    = '0;
      next_ptr = last_grant;
      if (enable) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (request[i] && (grant == '0)) begin
               grant[i] = 1'b1;
               next_ptr = 2'(i);
            end
         end
      end
   end
`else
   logic [1:0] cand;

   // Scan last_grant+1 .. last_grant+4 (mod 4); the first hit wins.
   always_comb begin
      grant    = '0;
      next_ptr = last_grant;
      cand     = last_grant;
      if (enable) begin
         for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = last_grant + 2'(k);
            if (request[cand] && (grant == '0)) begin
               grant[cand] = 1'b1;
               next_ptr    = cand;
            end
         end
      end
   end
`endif

endmodule

// File: rtl/egress_drain.sv
// egress_drain: drains four blue FIFOs into one 12-bit valid/ready stream.
//   clk, reset          single clock, synchronous active-high reset
//   Enable              allows new pops
//   empty_azules[3:0]   FIFO empty flags (one cycle stale)
//   data_p0..data_p3    FIFO read data, valid the cycle after pop
//   pop_azules[3:0]     one-hot FIFO read enable
//   ready_in            sink accepts data_out
//   data_out/valid_out/port_out  head of the 2-entry output buffer
//   req, idx            counter read request / index
//   cnt_data, cnt_valid counter read response, one cycle after req
//   idle                high in IDLE state
// Macro EGRESS_STRICT_PRIO_EN selects strict priority (p0 highest) instead
// of round-robin; the RR pointer register is then absent.
module egress_drain #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Enable,
   input  logic [3:0]        empty_azules,
   input  logic [DATA_W-1:0] data_p0,
   input  logic [DATA_W-1:0] data_p1,
   input  logic [DATA_W-1:0] data_p2,
   input  logic [DATA_W-1:0] data_p3,
   output logic [3:0]        pop_azules,
   input  logic              ready_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [1:0]        port_out,
   input  logic              req,
   input  logic [1:0]        idx,
   output logic [CNT_W-1:0]  cnt_data,
   output logic              cnt_valid,
   output logic              idle
);

   import egress_pkg::*;

   state_t            state, state_nx;
   logic [1:0]        occ;
   logic              inflight;
   logic [1:0]        inflight_port;
   logic [3:0]        last_pop;
   logic [DATA_W-1:0] buf_data [BUF_DEPTH];
   logic [1:0]        buf_port [BUF_DEPTH];
   logic [CNT_W-1:0]  cnt [NUM_PORTS];
   logic              deq, enq, pop_ok, tail_slot;
   logic [3:0]        eligible, grant;
   logic [1:0]        rr_ptr, next_ptr;
   logic [DATA_W-1:0] cap_data;

   assign deq       = valid_out & ready_in;
   assign enq       = inflight;
   assign eligible  = ~empty_azules & ~last_pop;
   // occ + inflight - deq < 2, rearranged to stay non-negative
   assign pop_ok    = (state == RUN) && Enable && !reset &&
                      (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, deq}));
   // Tail slot of the shift FIFO after this cycle's dequeue
   assign tail_slot = !((occ == 2'd0) || ((occ == 2'd1) && deq));

   assign valid_out  = (occ != 2'd0);
   assign data_out   = buf_data[0];
   assign port_out   = buf_port[0];
   assign pop_azules = grant;
   assign idle       = (state == IDLE);

   rr_arbiter_4 u_arb (
      .request    (eligible),
      .last_grant (rr_ptr),
      .enable     (pop_ok),
      .grant      (grant),
      .next_ptr   (next_ptr)
   );

`ifdef EGRESS_STRICT_PRIO_EN
   assign rr_ptr = 2'd3;
`else
   always_ff @(posedge clk) begin
      if (reset)       rr_ptr <= 2'd3;
      else if (|grant) rr_ptr <= next_ptr;
   end
`endif

   always_comb begin
      case (inflight_port)
         2'd0:    cap_data = data_p0;
         2'd1:    cap_data = data_p1;
         2'd2:    cap_data = data_p2;
         default: cap_data = data_p3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (Enable && (empty_azules != 4'hF)) state_nx = RUN;
         RUN:   if (!Enable)                          state_nx = DRAIN;
                else if ((occ == 2'd2) && !ready_in)  state_nx = STALL;
         STALL: if (!Enable)                          state_nx = DRAIN;
                else if (ready_in)                    state_nx = RUN;
         DRAIN: if (Enable)                           state_nx = RUN;
                else if ((occ == 2'd0) && !inflight)  state_nx = IDLE;
         default:                                     state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ           <= '0;
         inflight      <= 1'b0;
         inflight_port <= '0;
         last_pop      <= '0;
         cnt_data      <= '0;
         cnt_valid     <= 1'b0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            buf_data[i] <= '0;
            buf_port[i] <= '0;
         end
         for (int unsigned i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
      end else begin
         inflight <= |grant;
         last_pop <= grant;
         if (|grant) inflight_port <= next_ptr;

         // Shift on dequeue; a same-cycle enqueue into slot 0 overrides it.
         if (deq) begin
            buf_data[0] <= buf_data[1];
            buf_port[0] <= buf_port[1];
         end
         if (enq) begin
            buf_data[tail_slot] <= cap_data;
            buf_port[tail_slot] <= inflight_port;
         end
         occ <= occ + {1'b0, enq} - {1'b0, deq};

         if (deq) cnt[buf_port[0]] <= cnt[buf_port[0]] + 1'b1;
         if (req) begin
            cnt_data  <= cnt[idx];
            cnt_valid <= 1'b1;
         end else begin
            cnt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_egress_drain.sv
`timescale 1ns/1ps
module tb_egress_drain;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Enable = 1'b0;
   logic        ready_in = 1'b1;
   logic        req = 1'b0;
   logic [1:0]  idx = '0;
   logic [3:0]  empty_azules = '1;
   logic [11:0] fdata [4];
   logic [3:0]  pop_azules;
   logic [11:0] data_out;
   logic        valid_out;
   logic [1:0]  port_out;
   logic [4:0]  cnt_data;
   logic        cnt_valid;
   logic        idle;

   always #5 clk = ~clk;

   egress_drain #(.DATA_W(12), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .Enable(Enable), .empty_azules(empty_azules),
      .data_p0(fdata[0]), .data_p1(fdata[1]), .data_p2(fdata[2]), .data_p3(fdata[3]),
      .pop_azules(pop_azules), .ready_in(ready_in), .data_out(data_out),
      .valid_out(valid_out), .port_out(port_out), .req(req), .idx(idx),
      .cnt_data(cnt_data), .cnt_valid(cnt_valid), .idle(idle)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: source FIFOs, per-port expected streams, counters.
   logic [11:0] fq   [4][$];
   logic [11:0] expq [4][$];
   int unsigned mcnt [4];
   int unsigned cyc = 0, n_acc = 0, n_pop = 0;
   int unsigned acc_cyc[$], acc_port[$], pop_cyc[$];
   logic [3:0]  tb_last_pop = '0;
   logic        hold_v = 1'b0;
   logic [14:0] hold_val = '0;
   logic        pend = 1'b0;
   int unsigned pend_val = 0;
   logic [4:0]  prev_cd = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Blue FIFOs: empty flag reflects the depth before this edge's pop.
   always @(posedge clk) begin
      for (int p = 0; p < 4; p++) begin
         empty_azules[p] <= (fq[p].size() == 0);
         if (pop_azules[p] && fq[p].size() != 0) fdata[p] <= fq[p].pop_front();
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         for (int p = 0; p < 4; p++) mcnt[p] = 0;
         pend = 1'b0; prev_cd = '0; hold_v = 1'b0; tb_last_pop = '0;
      end else begin
         check("pop_onehot", 32'($onehot0(pop_azules)), 1);
         if (pop_azules != 4'd0) begin
            n_pop++;
            pop_cyc.push_back(cyc);
            for (int p = 0; p < 4; p++)
               if (pop_azules[p]) check("pop_nonempty", 32'(fq[p].size() != 0), 1);
`ifdef EGRESS_STRICT_PRIO_EN
            if (!empty_azules[0] && !tb_last_pop[0]) check("prio_p0", 32'(pop_azules), 32'h1);
`endif
         end
         tb_last_pop = pop_azules;

         if (hold_v) check("hold_out", 32'({valid_out, port_out, data_out}), 32'(hold_val));
         hold_v   = valid_out && !ready_in;
         hold_val = {valid_out, port_out, data_out};

         if (pend) begin
            check("cnt_valid", 32'(cnt_valid), 1);
            check("cnt_data", 32'(cnt_data), pend_val);
         end else begin
            check("cnt_valid_low", 32'(cnt_valid), 0);
            check("cnt_data_hold", 32'(cnt_data), 32'(prev_cd));
         end
         prev_cd  = cnt_data;
         pend     = req;
         pend_val = mcnt[idx];

         if (valid_out && ready_in) begin
            n_acc++;
            acc_cyc.push_back(cyc);
            acc_port.push_back(32'(port_out));
            if (expq[port_out].size() == 0) check("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
            else check("data_order", 32'(data_out), 32'(expq[port_out].pop_front()));
            mcnt[port_out] = (mcnt[port_out] + 1) % 32;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input int p, input logic [11:0] d);
      fq[p].push_back(d);
      expq[p].push_back(d);
   endtask

   task automatic clear_queues();
      for (int p = 0; p < 4; p++) begin
         fq[p].delete();
         expq[p].delete();
      end
   endtask

   task automatic clear_logs();
      acc_cyc.delete(); acc_port.delete(); pop_cyc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_queues();
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic wait_pop(input string tag);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pop_azules != 4'd0) return;
      end
      check(tag, 0, 1);
   endtask

   task automatic wait_acc(input string tag, input int unsigned target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (n_acc >= target) return;
         tick();
      end
      check(tag, n_acc, target);
   endtask

   function automatic int unsigned pending_words();
      int unsigned s = 0;
      for (int p = 0; p < 4; p++) s += expq[p].size();
      return s;
   endfunction

   task automatic wait_drained(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (pending_words() == 0 && !valid_out) return;
         tick();
      end
      check(tag, pending_words(), 0);
   endtask

   int unsigned base_pop, base_acc;

   initial begin
      repeat (3) tick();
      check("rst_pop", 32'(pop_azules), 0);
      check("rst_data_out", 32'(data_out), 0);
      check("rst_valid_out", 32'(valid_out), 0);
      check("rst_port_out", 32'(port_out), 0);
      check("rst_cnt_data", 32'(cnt_data), 0);
      check("rst_cnt_valid", 32'(cnt_valid), 0);
      check("rst_idle", 32'(idle), 1);
      reset = 1'b0;
      tick();

      // Reset one cycle after a pop discards the in-flight word.
      push(0, 12'h0AA);
      tick(); tick();
      Enable = 1'b1;
      wait_pop("rst_pop_timeout");
      tick();
      reset = 1'b1;
      clear_queues();
      tick();
      reset = 1'b0; Enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_no_valid", 32'(valid_out), 0);
      end
      check("rst_idle_after", 32'(idle), 1);

      // One word per port: delivered in port order, back to back, latency 2.
      clear_logs();
      push(0, 12'h001); push(1, 12'h102); push(2, 12'h203); push(3, 12'h304);
      tick(); tick();
      base_acc = n_acc;
      Enable = 1'b1; ready_in = 1'b1;
      wait_acc("order_timeout", base_acc + 4, 40);
      if (acc_port.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("order_port", acc_port[i], i);
         for (int i = 1; i < 4; i++) check("order_gap", acc_cyc[i] - acc_cyc[i-1], 1);
      end
      if (pop_cyc.size() >= 1 && acc_cyc.size() >= 1)
         check("pop_to_valid", acc_cyc[0] - pop_cyc[0], 2);

      // Single active port: one word every other cycle.
      tick(); tick();
      clear_logs();
      base_acc = n_acc;
      for (int i = 0; i < 3; i++) push(2, 12'(12'h2A0 + i));
      wait_acc("single_timeout", base_acc + 3, 40);
      if (acc_port.size() >= 3) begin
         for (int i = 0; i < 3; i++) check("single_port", acc_port[i], 2);
         for (int i = 1; i < 3; i++) check("single_gap", acc_cyc[i] - acc_cyc[i-1], 2);
      end

      // Backpressure: two words buffered, pops stop, then full recovery.
      tick(); tick();
      ready_in = 1'b0;
      base_pop = n_pop; base_acc = n_acc;
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 4; i++) push(p, 12'($urandom_range(0, 4095)));
      repeat (15) tick();
      check("stall_pops", n_pop - base_pop, 2);
      check("stall_valid", 32'(valid_out), 1);
      check("stall_idle", 32'(idle), 0);
      ready_in = 1'b1;
      wait_drained("stall_drain_timeout", 100);
      check("stall_total", n_acc - base_acc, 16);

      // Enable dropped with a word in flight: word still delivered, then IDLE.
      tick(); tick();
      base_acc = n_acc;
      push(1, 12'h5C3);
      wait_pop("drain_pop_timeout");
      tick();
      Enable = 1'b0;
      for (int i = 0; i < 20 && !idle; i++) tick();
      check("drain_delivered", n_acc - base_acc, 1);
      check("drain_idle", 32'(idle), 1);

      // 33 words on p1 wrap its counter to 1.
      do_reset();
      Enable = 1'b1; ready_in = 1'b1;
      for (int i = 0; i < 33; i++) push(1, 12'($urandom_range(0, 4095)));
      wait_acc("cnt_timeout", n_acc + 33, 200);
      tick(); tick();
      req = 1'b1; idx = 2'd1;
      tick();
      check("cnt_p1_valid", 32'(cnt_valid), 1);
      check("cnt_p1_wrap", 32'(cnt_data), 1);
      idx = 2'd0;
      tick();
      check("cnt_p0_zero", 32'(cnt_data), 0);
      req = 1'b0;
      tick();

      // Randomized traffic, backpressure, Enable toggles and counter reads.
      for (int i = 0; i < 800; i++) begin
         ready_in = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 49) == 0) Enable = ~Enable;
         if ($urandom_range(0, 3) == 0) push(int'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
         req = ($urandom_range(0, 4) == 0);
         idx = 2'($urandom_range(0, 3));
         tick();
      end
      req = 1'b0; Enable = 1'b1; ready_in = 1'b1;
      wait_drained("rand_drain_timeout", 600);
      tick(); tick();
      for (int p = 0; p < 4; p++) begin
         req = 1'b1; idx = 2'(p);
         tick();
         check("cnt_final", 32'(cnt_data), mcnt[p]);
      end
      req = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
